// File: rtl/muldiv_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_ctrl
//
// Purpose:
//   Multi-cycle multiply/divide unit with the architectural HI/LO register
//   pair. An op is accepted from the EX stage only while the unit is idle.
//   Multiply-class ops hold the unit busy for 5 cycles and divides for
//   10 cycles, counting the accepting cycle. The result is written to HI/LO
//   on the last busy edge.
//
// Ports:
//   clk          in   clock; all state changes on the rising edge
//   resetn       in   asynchronous active-low reset
//   MulOpE[3:0]  in   EX op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD,
//                     5 MADDU, 6 MSUB, 7 MSUBU, 8..15 none
//   MTHILOE[1:0] in   00 MTHI, 01 MTLO, 1x none
//   MFHILOE[1:0] in   01 MFHI, 10 MFLO, otherwise none
//   SrcAE[31:0]  in   rs operand (forwarded)
//   SrcBE[31:0]  in   rt operand (forwarded)
//   FlushE       in   EX instruction cancelled this cycle
//   Mul_BusyE    out  unit busy (start cycle through commit cycle)
//   HILOOutE     out  MFHI/MFLO read data, 0 when no read
//   HI, LO       out  architectural HI/LO registers
//   o_dbg_state  out  FSM state (0 idle, 1 mul, 2 div)
//
// Handshake: there is no valid/ready pair. The hazard unit stalls EX while
// Mul_BusyE is high. A non-flushed op seen while idle is accepted in that
// same cycle. Anything presented while the unit is not idle is dropped.
// ---------------------------------------------------------------------------
module muldiv_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  MulOpE,
    input  logic [1:0]  MTHILOE,
    input  logic [1:0]  MFHILOE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        FlushE,
    output logic        Mul_BusyE,
    output logic [31:0] HILOOutE,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [1:0]  o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_idle;
    logic        w_start;
    logic        w_start_div;
    logic        w_mt_we;
    logic        w_last;

    // ---------------- control ----------------
    assign w_idle      = (r_state == S_IDLE);
    // Ops 0..7 all have MulOpE[3] clear.
    assign w_start     = ~MulOpE[3] & ~FlushE & w_idle;
    assign w_start_div = (MulOpE[2:1] == 2'b01);
    // An op accepted in the same cycle wins over a move-to.
    assign w_mt_we     = ~MTHILOE[1] & ~FlushE & w_idle & ~w_start;
    // The counter is loaded with 4 (mul) or 9 (div). The commit happens on
    // the edge that takes it from 1 to 0, so the unit is busy for the start
    // cycle plus 4 or 9 further cycles. The counter rests at 0 when idle.
    assign w_last      = ~w_idle & (r_cnt == 4'd1);

    // ---------------- multiply datapath ----------------
    // An even op code means signed. This covers MULT, DIV, MADD and MSUB.
    logic        w_sgn;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [63:0] w_hilo;
    logic [63:0] w_mul_res;

    assign w_sgn   = ~r_op[0];
    assign w_ext_a = {{32{w_sgn & r_a[31]}}, r_a};
    assign w_ext_b = {{32{w_sgn & r_b[31]}}, r_b};
    // The low 64 bits of the extended product are correct for both signed
    // and unsigned operands.
    assign w_prod  = w_ext_a * w_ext_b;
    assign w_hilo  = {r_hi, r_lo};

    always_comb begin
        w_mul_res = w_prod;
        case (r_op[2:1])
            2'b10:   w_mul_res = w_hilo + w_prod;
            2'b11:   w_mul_res = w_hilo - w_prod;
            default: w_mul_res = w_prod;
        endcase
    end

    // ---------------- divide datapath ----------------
    // Divide the magnitudes, then restore the signs. The quotient is
    // negative when the operand signs differ. The remainder takes the
    // dividend's sign.
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_zero;

    assign w_a_neg    = w_sgn & r_a[31];
    assign w_b_neg    = w_sgn & r_b[31];
    assign w_abs_a    = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_abs_b    = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_div_zero = (r_b == 32'd0);
    // A zero divisor is replaced by 1 to keep the divider defined. Its
    // result is discarded anyway.
    assign w_div_b    = w_div_zero ? 32'd1 : w_abs_b;
    assign w_uq       = w_abs_a / w_div_b;
    assign w_ur       = w_abs_a % w_div_b;
    // 0x80000000 / -1 gives a magnitude of 0x80000000 with positive sign.
    // That wraps to LO = 0x80000000 and HI = 0, as required.
    assign w_quo      = (w_a_neg ^ w_b_neg) ? (~w_uq + 32'd1) : w_uq;
    assign w_rem      = w_a_neg ? (~w_ur + 32'd1) : w_ur;

    // ---------------- state ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= w_start_div ? S_DIV : S_MUL;
                        r_cnt   <= w_start_div ? 4'd9 : 4'd4;
                        r_op    <= MulOpE[2:0];
                        r_a     <= SrcAE;
                        r_b     <= SrcBE;
                    end else if (w_mt_we) begin
                        if (MTHILOE[0]) begin
                            r_lo <= SrcAE;
                        end else begin
                            r_hi <= SrcAE;
                        end
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_state      <= S_IDLE;
                        {r_hi, r_lo} <= w_mul_res;
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (w_last) begin
                        r_state <= S_IDLE;
                        if (!w_div_zero) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    // The outputs are gated with resetn. Busy must read 0 during reset even
    // when a valid op code is sitting on MulOpE.
    assign Mul_BusyE   = resetn & (w_start | ~w_idle);
    assign HI          = r_hi;
    assign LO          = r_lo;
    assign o_dbg_state = r_state;

    always_comb begin
        HILOOutE = 32'd0;
        if (resetn) begin
            case (MFHILOE)
                2'b01:   HILOOutE = r_hi;
                2'b10:   HILOOutE = r_lo;
                default: HILOOutE = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
module tb_muldiv_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  MulOpE;
  logic [1:0]  MTHILOE;
  logic [1:0]  MFHILOE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        FlushE;
  logic        Mul_BusyE;
  logic [31:0] HILOOutE;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk         (clk),
    .resetn      (resetn),
    .MulOpE      (MulOpE),
    .MTHILOE     (MTHILOE),
    .MFHILOE     (MFHILOE),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .FlushE      (FlushE),
    .Mul_BusyE   (Mul_BusyE),
    .HILOOutE    (HILOOutE),
    .HI          (HI),
    .LO          (LO),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model built on SV integer arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd0 || op == 4'd4 || op == 4'd6) p = sa * sb;
    else p = {32'd0, a} * {32'd0, b};
    res = hilo;
    case (op)
      4'd0, 4'd1: res = p;
      4'd4, 4'd5: res = hilo + p;
      4'd6, 4'd7: res = hilo - p;
      4'd2: if (b != 32'd0) begin
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      4'd3: if (b != 32'd0) res = {a % b, a / b};
      default: res = hilo;
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  // Issue one op, count busy cycles, then compare HI/LO with the scoreboard.
  // interfere: drive MULT and MTLO on busy cycles 2-4.
  // flush_i:   loop index at which FlushE pulses (0 means cycle 2; -1 means none).
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag, input bit interfere, input int flush_i);
    logic [63:0] exp;
    int          busy_n;
    int          exp_busy;
    bit          done;
    exp_busy = (op == 4'd2 || op == 4'd3) ? 10 : 5;
    @(negedge clk);
    MulOpE = op; SrcAE = a; SrcBE = b; MTHILOE = 2'b10; FlushE = 1'b0;
    exp = model(op, a, b, {m_hi, m_lo});
    exp_q.push_back(exp);
    {m_hi, m_lo} = exp;
    #1 check({tag, "_busy_start"}, {63'd0, Mul_BusyE}, 64'd1);
    busy_n = 1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      FlushE = (i == flush_i);
      if (interfere && i < 3) begin
        MulOpE = 4'b0000; SrcAE = $urandom; SrcBE = $urandom; MTHILOE = 2'b01;
      end else begin
        MulOpE = 4'b1000; MTHILOE = 2'b10;
      end
      #1;
      if (Mul_BusyE) busy_n++;
      else done = 1'b1;
    end
    FlushE = 1'b0;
    check({tag, "_busy_len"}, 64'(busy_n), 64'(exp_busy));
    check({tag, "_hilo"}, {HI, LO}, exp_q.pop_front());
  endtask

  task automatic mt(input logic [1:0] sel, input logic [31:0] val, input string tag);
    @(negedge clk);
    MulOpE = 4'b1000; MTHILOE = sel; SrcAE = val;
    #1 check({tag, "_busy"}, {63'd0, Mul_BusyE}, 64'd0);
    if (sel == 2'b00) m_hi = val;
    else m_lo = val;
    @(negedge clk);
    MTHILOE = 2'b10;
    #1 check({tag, "_hilo"}, {HI, LO}, {m_hi, m_lo});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0; MulOpE = 4'b0000; MTHILOE = 2'b10; MFHILOE = 2'b01;
    SrcAE = 32'h1234; SrcBE = 32'h5678; FlushE = 1'b0;
    #3;
    check("rst_busy", {63'd0, Mul_BusyE}, 64'd0);
    check("rst_hilo", {HI, LO}, 64'd0);
    check("rst_hiloout", {32'd0, HILOOutE}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    @(negedge clk); @(negedge clk);
    MulOpE = 4'b1000; MFHILOE = 2'b00;
    resetn = 1'b1;

    do_op(4'd0, 32'hFFFFFFFF, 32'd2, "mult", 1'b0, -1);
    do_op(4'd1, 32'hFFFFFFFF, 32'd2, "multu", 1'b0, -1);
    check("multu_lit", {HI, LO}, 64'h00000001_FFFFFFFE);
    do_op(4'd2, 32'hFFFFFFF9, 32'd2, "div", 1'b0, -1);
    check("div_lit", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4'd3, 32'd7, 32'd0, "divu_zero", 1'b0, -1);
    check("divu_zero_lit", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 1'b0, -1);
    check("div_ovf_lit", {HI, LO}, 64'h00000000_80000000);

    mt(2'b00, 32'h1, "mthi");
    mt(2'b01, 32'h0, "mtlo");
    do_op(4'd5, 32'hFFFFFFFF, 32'd1, "maddu", 1'b0, -1);
    check("maddu_lit", {HI, LO}, 64'h00000001_FFFFFFFF);
    do_op(4'd6, 32'd1, 32'd1, "msub", 1'b0, -1);
    check("msub_lit", {HI, LO}, 64'h00000001_FFFFFFFE);
    do_op(4'd4, 32'hFFFFFFF0, 32'd3, "madd", 1'b0, -1);
    do_op(4'd7, 32'h80000000, 32'h4, "msubu", 1'b0, -1);

    // New MULT and MTLO while busy are ignored.
    do_op(4'd0, 32'd1000, 32'hFFFFFFFD, "mult_interfere", 1'b1, -1);

    // A flushed op in the start cycle is suppressed.
    @(negedge clk);
    MulOpE = 4'b0000; SrcAE = 32'd5; SrcBE = 32'd6; FlushE = 1'b1;
    #1 check("flush_start_busy", {63'd0, Mul_BusyE}, 64'd0);
    @(negedge clk);
    MulOpE = 4'b1000; FlushE = 1'b0;
    #1 check("flush_start_state", {62'd0, dbg_state}, 64'd0);
    check("flush_start_hilo", {HI, LO}, {m_hi, m_lo});

    // A flush during a running DIV does not cancel it.
    do_op(4'd2, 32'd100, 32'hFFFFFFF9, "div_flush", 1'b0, 0);

    for (int k = 0; k < 4; k++) begin
      logic [3:0] rop;
      rop = 4'($urandom_range(0, 7));
      do_op(rop, $urandom, $urandom, $sformatf("rand%0d", k), 1'b0, -1);
    end

    // Reset on cycle 3 of a DIV abandons it.
    mt(2'b00, 32'hDEAD0001, "pre_rst_hi");
    @(negedge clk);
    MulOpE = 4'b0010; SrcAE = 32'd100; SrcBE = 32'd7;
    #1 check("rstdiv_busy", {63'd0, Mul_BusyE}, 64'd1);
    @(negedge clk);
    MulOpE = 4'b1000;
    @(negedge clk);
    resetn = 1'b0; MulOpE = 4'b0000; MFHILOE = 2'b01;
    #1;
    check("rstdiv_busy0", {63'd0, Mul_BusyE}, 64'd0);
    check("rstdiv_hilo", {HI, LO}, 64'd0);
    check("rstdiv_hiloout", {32'd0, HILOOutE}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk); @(negedge clk);
    MulOpE = 4'b1000; MFHILOE = 2'b00;
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("rstdiv_nocommit", {HI, LO}, 64'd0);
    check("rstdiv_state", {62'd0, dbg_state}, 64'd0);

    // MFHI/MFLO read-back.
    do_op(4'd1, 32'h12345678, 32'h00010010, "multu_mf", 1'b0, -1);
    @(negedge clk);
    MFHILOE = 2'b10;
    #1 check("mflo", {32'd0, HILOOutE}, {32'd0, m_lo});
    @(negedge clk);
    MFHILOE = 2'b01;
    #1 check("mfhi", {32'd0, HILOOutE}, {32'd0, m_hi});
    @(negedge clk);
    MFHILOE = 2'b11;
    #1 check("mf_none", {32'd0, HILOOutE}, 64'd0);
    MFHILOE = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have the port `clk`, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have the port `resetn`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have the port `MulOpE`, input, 4 bits: EX-stage op code.
  - 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU.
  - 0100 MADD, 0101 MADDU, 0110 MSUB, 0111 MSUBU.
  - 1000 none; 1001-1111 treated as none.
REQ-004 SHALL have the port `MTHILOE`, input, 2 bits: 00 MTHI, 01 MTLO, 10/11 none.
REQ-005 SHALL have the port `MFHILOE`, input, 2 bits: 00 none, 01 MFHI, 10 MFLO, 11 none.
REQ-006 SHALL have the port `SrcAE`, input, 32 bits: rs operand, already forwarded.
REQ-007 SHALL have the port `SrcBE`, input, 32 bits: rt operand, already forwarded.
REQ-008 SHALL have the port `FlushE`, input, 1 bit: the EX instruction is cancelled this cycle.
REQ-009 SHALL have the port `Mul_BusyE`, output, 1 bit: unit busy, to the hazard unit.
REQ-010 SHALL have the port `HILOOutE`, output, 32 bits: MFHI/MFLO read data.
REQ-011 SHALL have the port `HI`, output, 32 bits: architectural HI register.
REQ-012 SHALL have the port `LO`, output, 32 bits: architectural LO register.

Function
REQ-013 SHALL define Start = (MulOpE in 0000..0111) & ~FlushE & (State==IDLE).
REQ-014 SHALL implement a state machine with states IDLE, MUL, DIV and a 4-bit down-counter Cnt.
REQ-015 SHALL handle Start as follows.
  - Mult-class op: State->MUL, Cnt->4.
  - DIV/DIVU: State->DIV, Cnt->9.
  - Operands and op code latched on the same edge.
REQ-016 SHALL handle MUL/DIV states as follows.
  - Cnt decrements each cycle.
  - On the edge where Cnt==0: result committed to HI/LO, State->IDLE.
  - Busy duration: 5 cycles for MUL (Start cycle plus 4), 10 cycles for DIV.
REQ-017 SHALL drive Mul_BusyE = Start | (State!=IDLE), combinationally.
  - It is high in the Start cycle and through the commit cycle.
  - It is low in the cycle after commit.
REQ-018 SHALL compute MULT/MADD/MSUB signed and the U variants unsigned, with a 64-bit product.
  - MULT/MULTU: {HI,LO} = product.
  - MADD(U): {HI,LO} = {HI,LO} + product, mod 2^64.
  - MSUB(U): {HI,LO} = {HI,LO} - product, mod 2^64.
  - The {HI,LO} operand is the value at commit time.
REQ-019 SHALL compute DIV signed and DIVU unsigned.
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-020 SHALL handle divisor==0 as follows: busy for the full 10 cycles, HI and LO unchanged at commit.
REQ-021 SHALL, when MTHILOE is 00/01 and ~FlushE and State==IDLE and no Start this cycle, write SrcAE to HI (MTHI) or LO (MTLO) on the next edge.
REQ-022 SHALL ignore MTHI/MTLO when busy or flushed; the hazard unit guarantees they do not arrive while busy.
REQ-023 SHALL drive HILOOutE combinationally.
  - MFHI: HI. MFLO: LO. Otherwise 0.
  - The value reflects registers at their current state; there is no internal bypass of an in-flight result.
REQ-024 SHALL ignore a Start attempt while State!=IDLE; no restart, no queueing.
REQ-025 SHALL not cancel an operation already past its Start edge when FlushE is asserted; only a Start in the same cycle as FlushE is suppressed.
REQ-026 SHALL, if MulOpE is a mult/div op and MTHILOE is active in the same cycle, give the op priority and drop the MT write.

Reset
REQ-027 SHALL, on resetn low and asynchronously, set State=IDLE, Cnt=0, HI=0, LO=0 and clear the latched operands/op.
REQ-028 SHALL, while resetn is low, drive Mul_BusyE=0 and HILOOutE=0 (MFHILOE=00 is not assumed).
REQ-029 SHALL, on reset mid-operation, abandon the operation with no HI/LO commit; the first edge after release sees IDLE.

Verification
REQ-030 SHALL cover this scenario: MULT A=0xFFFFFFFF, B=2 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=1, LO=0xFFFFFFFE.
REQ-031 SHALL cover this scenario: DIV A=-7, B=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 -> HI/LO unchanged, Busy 10 cycles.
REQ-032 SHALL cover this scenario: MTHI 0x1, MTLO 0x0, then MADDU A=0xFFFFFFFF, B=1 -> HI=0x1, LO=0xFFFFFFFF. Then MSUB A=1, B=1 -> HI=0x1, LO=0xFFFFFFFE.
REQ-033 SHALL cover this scenario: MULT started, new MULT and MTLO presented on cycles 2-4 -> both ignored, Busy unaffected, result from the first op only.
REQ-034 SHALL cover this scenario: MULT with FlushE=1 in the Start cycle -> Mul_BusyE=0 in that cycle (Start suppressed), no state change. Separately, FlushE raised on cycle 2 of a running DIV -> DIV still completes.
REQ-035 SHALL cover this scenario: resetn pulsed low on cycle 3 of DIV -> HI=LO=0, Busy=0 immediately, no later commit. MFLO after completion returns LO.
